// File: rtl/msk_op_sequencer_pkg.sv
// Shared types and helpers for the masked-op sequencer.
// Contents:
//   msk_op_t    - 4-bit opcode of the masked bitwise/shift unit (codes 9..15 illegal)
//   state_t     - sequencer FSM states
//   op_legal    - 1 when the opcode is one the unit implements
//   op_onehot   - 9-bit one-hot unit opcode, bit n set for opcode n, zero for illegal codes
package msk_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOT     = 4'd0,
        OP_AND     = 4'd1,
        OP_XOR     = 4'd2,
        OP_IOR     = 4'd3,
        OP_SLLI    = 4'd4,
        OP_SRLI    = 4'd5,
        OP_RORI    = 4'd6,
        OP_BMASK   = 4'd7,
        OP_BREMASK = 4'd8
    } msk_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    function automatic logic op_legal(input msk_op_t op);
        return (4'(op) <= 4'd8);
    endfunction

    function automatic logic [8:0] op_onehot(input msk_op_t op);
        logic [8:0] oh;
        case (op)
            OP_NOT:     oh = 9'h001;
            OP_AND:     oh = 9'h002;
            OP_XOR:     oh = 9'h004;
            OP_IOR:     oh = 9'h008;
            OP_SLLI:    oh = 9'h010;
            OP_SRLI:    oh = 9'h020;
            OP_RORI:    oh = 9'h040;
            OP_BMASK:   oh = 9'h080;
            OP_BREMASK: oh = 9'h100;
            default:    oh = 9'h000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/msk_op_sequencer_if.sv
// Bus between the sequencer and the masked bitwise/shift unit.
//   valid/op/rs*_s*  : operation request with operand shares (sequencer -> unit)
//   flush/prng_update: pipeline flush and randomness refresh strobes (sequencer -> unit)
//   ready/rd_s*      : completion and result shares (unit -> sequencer)
// master = sequencer side, slave = unit side.
interface msk_unit_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            flush;
    logic            prng_update;
    logic [8:0]      op;
    logic [XLEN-1:0] rs1_s0;
    logic [XLEN-1:0] rs1_s1;
    logic [XLEN-1:0] rs2_s0;
    logic [XLEN-1:0] rs2_s1;
    logic            ready;
    logic [XLEN-1:0] rd_s0;
    logic [XLEN-1:0] rd_s1;

    modport master (
        output valid, flush, prng_update, op, rs1_s0, rs1_s1, rs2_s0, rs2_s1,
        input  ready, rd_s0, rd_s1
    );

    modport slave (
        input  valid, flush, prng_update, op, rs1_s0, rs1_s1, rs2_s0, rs2_s1,
        output ready, rd_s0, rd_s1
    );
endinterface

// File: rtl/msk_op_sequencer_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer favours requester 0)
//   req      : request vector
//   advance  : a grant was consumed this cycle; pointer moves to the other requester
//   gnt      : one-hot or zero grant (combinational)
module msk_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    // ptr_r = 0 favours requester 0 on a tie, 1 favours requester 1
    logic ptr_r;

    // Grant decode: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer update: after a consumed grant, favour the requester that lost
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end
    end
endmodule

// File: rtl/msk_op_sequencer.sv
// Front-end controller for the masked bitwise/shift unit.
// Arbitrates between core issue (requester 0) and the remask engine (requester 1),
// runs one op at a time on the unit, returns the result with the requester id and
// then spends one cycle flushing the unit and refreshing its PRNG.
//   g_clk, g_reset          : clock, synchronous active-high reset
//   rq_valid/rq_ready       : per-requester handshake (ready one-hot or zero, IDLE only)
//   rq_op, rq_rs*_s*        : per-requester opcode and operand shares, requester n in slice n
//   u                       : unit bus (master side)
//   rsp_valid/rsp_ready     : response handshake
//   rsp_id/rsp_err/rsp_rd_* : requester id, timeout/illegal-op flag, result shares
module msk_op_sequencer
    import msk_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic [1:0]        rq_valid,
    output logic [1:0]        rq_ready,
    input  logic [7:0]        rq_op,
    input  logic [2*XLEN-1:0] rq_rs1_s0,
    input  logic [2*XLEN-1:0] rq_rs1_s1,
    input  logic [2*XLEN-1:0] rq_rs2_s0,
    input  logic [2*XLEN-1:0] rq_rs2_s1,
    msk_unit_if.master        u,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [XLEN-1:0]   rsp_rd_s0,
    output logic [XLEN-1:0]   rsp_rd_s1
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            u_valid_r;
    logic            flush_r;
    logic            prng_r;
    logic [8:0]      u_op_r;
    logic [XLEN-1:0] u_rs1_s0_r, u_rs1_s1_r, u_rs2_s0_r, u_rs2_s1_r;
    logic            rsp_valid_r, rsp_id_r, rsp_err_r;
    logic [XLEN-1:0] rsp_rd_s0_r, rsp_rd_s1_r;

    logic [1:0]      gnt_s;
    logic            gid_s;
    logic            hs_s;
    msk_op_t         sel_op_s;
    logic [XLEN-1:0] sel_rs1_s0_s, sel_rs1_s1_s, sel_rs2_s0_s, sel_rs2_s1_s;
    logic [XLEN-1:0] shp_rs2_s0_s, shp_rs2_s1_s;

    msk_rr_arb2 u_arb (
        .clk     (g_clk),
        .rst     (g_reset),
        .req     (rq_valid),
        .advance (hs_s),
        .gnt     (gnt_s)
    );

    // Handshake happens only in IDLE; any valid request produces a grant there
    assign hs_s = (state_r == ST_IDLE) && (gnt_s != 2'b00);

    // Accept strobe: the arbiter grant, exposed only while IDLE
    always_comb begin
        if (state_r == ST_IDLE) begin
            rq_ready = gnt_s;
        end else begin
            rq_ready = 2'b00;
        end
    end

    // Select the granted requester's opcode and operand slice
    always_comb begin
        gid_s = gnt_s[1];
        if (gid_s) begin
            sel_op_s     = msk_op_t'(rq_op[7:4]);
            sel_rs1_s0_s = rq_rs1_s0[2*XLEN-1:XLEN];
            sel_rs1_s1_s = rq_rs1_s1[2*XLEN-1:XLEN];
            sel_rs2_s0_s = rq_rs2_s0[2*XLEN-1:XLEN];
            sel_rs2_s1_s = rq_rs2_s1[2*XLEN-1:XLEN];
        end else begin
            sel_op_s     = msk_op_t'(rq_op[3:0]);
            sel_rs1_s0_s = rq_rs1_s0[XLEN-1:0];
            sel_rs1_s1_s = rq_rs1_s1[XLEN-1:0];
            sel_rs2_s0_s = rq_rs2_s0[XLEN-1:0];
            sel_rs2_s1_s = rq_rs2_s1[XLEN-1:0];
        end
    end

    // Operand 2 shaping: shift amounts are public (share 0 low bits only),
    // unary ops get no second operand so no stale share reaches the unit
    always_comb begin
        case (sel_op_s)
            OP_SLLI, OP_SRLI, OP_RORI: begin
                shp_rs2_s0_s = {{(XLEN-5){1'b0}}, sel_rs2_s0_s[4:0]};
                shp_rs2_s1_s = {XLEN{1'b0}};
            end
            OP_NOT, OP_BMASK, OP_BREMASK: begin
                shp_rs2_s0_s = {XLEN{1'b0}};
                shp_rs2_s1_s = {XLEN{1'b0}};
            end
            default: begin
                shp_rs2_s0_s = sel_rs2_s0_s;
                shp_rs2_s1_s = sel_rs2_s1_s;
            end
        endcase
    end

    // Sequencer FSM with registered unit-side and response-side outputs
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            u_valid_r   <= 1'b0;
            flush_r     <= 1'b0;
            prng_r      <= 1'b0;
            u_op_r      <= 9'h000;
            u_rs1_s0_r  <= {XLEN{1'b0}};
            u_rs1_s1_r  <= {XLEN{1'b0}};
            u_rs2_s0_r  <= {XLEN{1'b0}};
            u_rs2_s1_r  <= {XLEN{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rd_s0_r <= {XLEN{1'b0}};
            rsp_rd_s1_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        rsp_id_r <= gid_s;
                        if (op_legal(sel_op_s)) begin
                            state_r    <= ST_BUSY;
                            cnt_r      <= CW'(1);
                            u_valid_r  <= 1'b1;
                            u_op_r     <= op_onehot(sel_op_s);
                            u_rs1_s0_r <= sel_rs1_s0_s;
                            u_rs1_s1_r <= sel_rs1_s1_s;
                            u_rs2_s0_r <= shp_rs2_s0_s;
                            u_rs2_s1_r <= shp_rs2_s1_s;
                        end else begin
                            // Illegal opcode: answer with an error, never touch the unit
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rd_s0_r <= {XLEN{1'b0}};
                            rsp_rd_s1_r <= {XLEN{1'b0}};
                        end
                    end
                end
                ST_BUSY: begin
                    // u_ready takes priority over the timeout in the same cycle
                    if (u.ready || (cnt_r == CW'(TIMEOUT))) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= ~u.ready;
                        rsp_rd_s0_r <= u.ready ? u.rd_s0 : {XLEN{1'b0}};
                        rsp_rd_s1_r <= u.ready ? u.rd_s1 : {XLEN{1'b0}};
                        u_valid_r   <= 1'b0;
                        u_op_r      <= 9'h000;
                        u_rs1_s0_r  <= {XLEN{1'b0}};
                        u_rs1_s1_r  <= {XLEN{1'b0}};
                        u_rs2_s0_r  <= {XLEN{1'b0}};
                        u_rs2_s1_r  <= {XLEN{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_FLUSH;
                        rsp_valid_r <= 1'b0;
                        flush_r     <= 1'b1;
                        prng_r      <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_IDLE;
                    flush_r <= 1'b0;
                    prng_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign u.valid       = u_valid_r;
    assign u.flush       = g_reset | flush_r;
    assign u.prng_update = prng_r;
    assign u.op          = u_op_r;
    assign u.rs1_s0      = u_rs1_s0_r;
    assign u.rs1_s1      = u_rs1_s1_r;
    assign u.rs2_s0      = u_rs2_s0_r;
    assign u.rs2_s1      = u_rs2_s1_r;

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rd_s0 = rsp_rd_s0_r;
    assign rsp_rd_s1 = rsp_rd_s1_r;
endmodule

// File: tb/tb_msk_op_sequencer.sv
module tb_msk_op_sequencer;
    import msk_seq_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic [7:0]  rq_op;
    logic [63:0] rq_rs1_s0, rq_rs1_s1, rq_rs2_s0, rq_rs2_s1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_rd_s0, rsp_rd_s1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 g_clk = ~g_clk;

    msk_unit_if #(.XLEN(XLEN)) uif ();

    msk_op_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .rq_valid  (rq_valid),
        .rq_ready  (rq_ready),
        .rq_op     (rq_op),
        .rq_rs1_s0 (rq_rs1_s0),
        .rq_rs1_s1 (rq_rs1_s1),
        .rq_rs2_s0 (rq_rs2_s0),
        .rq_rs2_s1 (rq_rs2_s1),
        .u         (uif),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_rd_s0 (rsp_rd_s0),
        .rsp_rd_s1 (rsp_rd_s1)
    );

    // Unmasked reference of the unit's operations
    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] rot;
        rot = {a, a} >> b[4:0];
        case (op)
            4'd0:       return ~a;
            4'd1:       return a & b;
            4'd2:       return a ^ b;
            4'd3:       return a | b;
            4'd4:       return a << b[4:0];
            4'd5:       return a >> b[4:0];
            4'd6:       return rot[31:0];
            4'd7, 4'd8: return a;
            default:    return 32'h0;
        endcase
    endfunction

    // ---------------- unit model ----------------
    int          ready_lat = 1;
    bit          unit_dead = 1'b0;
    bit          ready_tie = 1'b0;
    int          busy_cnt  = 0;
    logic [31:0] mask_r    = 32'h0;
    logic [31:0] u_res;

    always @(posedge g_clk) begin
        busy_cnt <= uif.valid ? busy_cnt + 1 : 0;
        mask_r   <= $urandom;
    end

    always_comb begin
        u_res = 32'h0;
        for (int i = 0; i < 9; i++)
            if (uif.op == (9'd1 << i))
                u_res = ref_op(4'(i), uif.rs1_s0 ^ uif.rs1_s1, uif.rs2_s0 ^ uif.rs2_s1);
    end

    assign uif.ready = ready_tie | (uif.valid & ~unit_dead & ((busy_cnt + 1) >= ready_lat));
    assign uif.rd_s0 = mask_r;
    assign uif.rd_s1 = u_res ^ mask_r;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge g_clk) begin
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a, b;
        if (!g_reset) begin
            for (int i = 0; i < 2; i++) begin
                if (rq_valid[i] && rq_ready[i]) begin
                    op = rq_op[4*i +: 4];
                    a  = rq_rs1_s0[32*i +: 32] ^ rq_rs1_s1[32*i +: 32];
                    b  = (op >= 4'd4 && op <= 4'd6) ? rq_rs2_s0[32*i +: 32]
                                                    : (rq_rs2_s0[32*i +: 32] ^ rq_rs2_s1[32*i +: 32]);
                    e.id = i[0];
                    if (op > 4'd8 || unit_dead) begin
                        e.err = 1'b1;
                        e.val = 32'h0;
                    end else begin
                        e.err = 1'b0;
                        e.val = ref_op(op, a, b);
                    end
                    sb_q.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got response id=%0d err=%0d, required none", rsp_id, rsp_err);
                end else begin
                    n_pass++;
                    e = sb_q.pop_front();
                    n_checks++;
                    if ({rsp_id, rsp_err} !== {e.id, e.err})
                        $display("FAIL rsp_id_err: got id=%0d err=%0d, required id=%0d err=%0d", rsp_id, rsp_err, e.id, e.err);
                    else n_pass++;
                    n_checks++;
                    if ((rsp_rd_s0 ^ rsp_rd_s1) !== e.val)
                        $display("FAIL rsp_value: got %h, required %h", rsp_rd_s0 ^ rsp_rd_s1, e.val);
                    else n_pass++;
                    if (e.err) begin
                        n_checks++;
                        if ({rsp_rd_s0, rsp_rd_s1} !== 64'h0)
                            $display("FAIL rsp_err_zero: got %h/%h, required 0/0", rsp_rd_s0, rsp_rd_s1);
                        else n_pass++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input int id, input logic [3:0] op, input logic [31:0] r1s0,
                             input logic [31:0] r1s1, input logic [31:0] r2s0, input logic [31:0] r2s1);
        rq_op[4*id +: 4]      = op;
        rq_rs1_s0[32*id +: 32] = r1s0;
        rq_rs1_s1[32*id +: 32] = r1s1;
        rq_rs2_s0[32*id +: 32] = r2s0;
        rq_rs2_s1[32*id +: 32] = r2s1;
        rq_valid[id]           = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        bit got = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge g_clk);
            if (rq_ready[id]) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL grant_timeout: requester %0d got no grant, required a grant within 200 cycles", id);
        end
        @(posedge g_clk); #1;
        rq_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge g_clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL rsp_timeout: no rsp_valid, required one within 300 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        g_reset = 1'b1;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        n_checks++;
        if ({rq_ready, uif.valid, uif.prng_update, uif.op} !== 13'h0)
            $display("FAIL reset_ctrl: got rq_ready=%b u_valid=%b prng=%b u_op=%h, required all 0",
                     rq_ready, uif.valid, uif.prng_update, uif.op);
        else n_pass++;
        n_checks++;
        if ({uif.rs1_s0, uif.rs1_s1, uif.rs2_s0, uif.rs2_s1} !== 128'h0)
            $display("FAIL reset_operands: got nonzero unit operands, required 0");
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_id, rsp_rd_s0, rsp_rd_s1} !== 67'h0)
            $display("FAIL reset_rsp: got valid=%b err=%b id=%b rd=%h/%h, required all 0",
                     rsp_valid, rsp_err, rsp_id, rsp_rd_s0, rsp_rd_s1);
        else n_pass++;
        n_checks++;
        if (uif.flush !== 1'b1) $display("FAIL reset_flush: got u_flush=%b, required 1", uif.flush);
        else n_pass++;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        @(negedge g_clk);
        n_checks++;
        if (uif.flush !== 1'b0) $display("FAIL idle_flush: got u_flush=%b, required 0", uif.flush);
        else n_pass++;
        @(posedge g_clk); #1;
    endtask

    task automatic test_xor();
        int lat;
        ready_lat = 2;
        drive_req(0, 4'd2, 32'h0484D609, 32'h31F05663, 32'h0, 32'h0);
        wait_grant(0);
        n_checks++;
        if ({uif.valid, uif.op} !== {1'b1, 9'h004})
            $display("FAIL xor_uop: got valid=%b u_op=%h, required 1/004", uif.valid, uif.op);
        else n_pass++;
        wait_rsp(lat);
        n_checks++;
        if (lat !== 3) $display("FAIL xor_latency: got %0d cycles, required 3", lat);
        else n_pass++;
        n_checks++;
        if ({rsp_id, rsp_rd_s0 ^ rsp_rd_s1} !== {1'b0, 32'h3574806A})
            $display("FAIL xor_result: got id=%0d rd=%h, required id=0 rd=3574806a", rsp_id, rsp_rd_s0 ^ rsp_rd_s1);
        else n_pass++;
        @(negedge g_clk);
        n_checks++;
        if ({uif.flush, uif.prng_update, rsp_valid} !== 3'b110)
            $display("FAIL flush_cycle: got flush=%b prng=%b rsp_valid=%b, required 1/1/0",
                     uif.flush, uif.prng_update, rsp_valid);
        else n_pass++;
        @(negedge g_clk);
        n_checks++;
        if ({uif.flush, uif.prng_update} !== 2'b00)
            $display("FAIL flush_one_cycle: got flush=%b prng=%b, required 0/0", uif.flush, uif.prng_update);
        else n_pass++;
        @(posedge g_clk); #1;
    endtask

    task automatic test_slli();
        int lat;
        ready_lat = 1;
        drive_req(1, 4'd4, 32'h80000001, 32'h0, 32'hFFFFFFE1, 32'h12345678);
        wait_grant(1);
        n_checks++;
        if ({uif.op, uif.rs2_s0, uif.rs2_s1} !== {9'h010, 32'h1, 32'h0})
            $display("FAIL slli_operands: got u_op=%h rs2=%h/%h, required 010 00000001/00000000",
                     uif.op, uif.rs2_s0, uif.rs2_s1);
        else n_pass++;
        wait_rsp(lat);
        n_checks++;
        if ({rsp_id, rsp_rd_s0 ^ rsp_rd_s1} !== {1'b1, 32'h00000002})
            $display("FAIL slli_result: got id=%0d rd=%h, required id=1 rd=00000002", rsp_id, rsp_rd_s0 ^ rsp_rd_s1);
        else n_pass++;
        @(posedge g_clk); #1;
    endtask

    task automatic test_back_to_back();
        bit         got;
        logic [1:0] exp_g;
        int         gid;
        ready_lat = 3;
        drive_req(0, 4'($urandom_range(8, 0)), $urandom, $urandom, $urandom, $urandom);
        drive_req(1, 4'($urandom_range(8, 0)), $urandom, $urandom, $urandom, $urandom);
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge g_clk);
                if (rq_ready != 2'b00) got = 1'b1;
            end
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (rq_ready !== exp_g) $display("FAIL rr_grant_%0d: got rq_ready=%b, required %b", g, rq_ready, exp_g);
            else n_pass++;
            gid = rq_ready[1] ? 1 : 0;
            @(posedge g_clk); #1;
            if (g < 4) drive_req(gid, 4'($urandom_range(8, 0)), $urandom, $urandom, $urandom, $urandom);
            else rq_valid[gid] = 1'b0;
            // change the stalled requester's inputs; only the value at its own grant may count
            if (rq_valid[1-gid])
                drive_req(1 - gid, 4'($urandom_range(8, 0)), $urandom, $urandom, $urandom, $urandom);
        end
        for (int w = 0; w < 300 && sb_q.size() != 0; w++) @(negedge g_clk);
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL rr_drain: got %0d outstanding, required 0", sb_q.size());
        else n_pass++;
        @(posedge g_clk); #1;
    endtask

    task automatic test_bmask();
        int          lat;
        logic [31:0] v, m;
        v = $urandom;
        m = $urandom;
        ready_tie = 1'b1;
        drive_req(0, 4'd7, v ^ m, m, $urandom, $urandom);
        wait_grant(0);
        n_checks++;
        if ({uif.op, uif.rs2_s0, uif.rs2_s1} !== {9'h080, 64'h0})
            $display("FAIL bmask_operands: got u_op=%h rs2=%h/%h, required 080 0/0", uif.op, uif.rs2_s0, uif.rs2_s1);
        else n_pass++;
        wait_rsp(lat);
        n_checks++;
        if (lat !== 2) $display("FAIL bmask_latency: got %0d cycles, required 2", lat);
        else n_pass++;
        n_checks++;
        if ({rsp_err, rsp_rd_s0 ^ rsp_rd_s1} !== {1'b0, v})
            $display("FAIL bmask_result: got err=%b rd=%h, required err=0 rd=%h", rsp_err, rsp_rd_s0 ^ rsp_rd_s1, v);
        else n_pass++;
        @(posedge g_clk); #1;
        ready_tie = 1'b0;
    endtask

    task automatic test_timeout();
        int lat;
        unit_dead = 1'b1;
        drive_req(1, 4'd2, $urandom, $urandom, $urandom, $urandom);
        wait_grant(1);
        wait_rsp(lat);
        n_checks++;
        if (lat !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d cycles, required %0d", lat, TIMEOUT + 1);
        else n_pass++;
        n_checks++;
        if ({rsp_err, rsp_rd_s0, rsp_rd_s1} !== {1'b1, 64'h0})
            $display("FAIL timeout_err: got err=%b rd=%h/%h, required 1 0/0", rsp_err, rsp_rd_s0, rsp_rd_s1);
        else n_pass++;
        @(posedge g_clk); #1;
        unit_dead = 1'b0;
    endtask

    task automatic test_illegal();
        int lat;
        drive_req(0, 4'd12, $urandom, $urandom, $urandom, $urandom);
        wait_grant(0);
        n_checks++;
        if ({uif.valid, uif.op} !== 10'h0) $display("FAIL illegal_unit: got u_valid=%b u_op=%h, required 0", uif.valid, uif.op);
        else n_pass++;
        wait_rsp(lat);
        n_checks++;
        if ({lat, rsp_err, uif.valid} !== {32'd1, 1'b1, 1'b0})
            $display("FAIL illegal_rsp: got lat=%0d err=%b u_valid=%b, required 1/1/0", lat, rsp_err, uif.valid);
        else n_pass++;
        @(posedge g_clk); #1;
    endtask

    task automatic test_rsp_stall();
        int          lat;
        logic [65:0] snap;
        ready_lat = 1;
        rsp_ready = 1'b0;
        drive_req(0, 4'd1, $urandom, $urandom, $urandom, $urandom);
        wait_grant(0);
        wait_rsp(lat);
        snap = {rsp_id, rsp_err, rsp_rd_s0, rsp_rd_s1};
        @(posedge g_clk); #1;
        drive_req(1, 4'd3, $urandom, $urandom, $urandom, $urandom);
        for (int c = 0; c < 10; c++) begin
            @(negedge g_clk);
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_rd_s0, rsp_rd_s1, rq_ready} !== {1'b1, snap, 2'b00})
                $display("FAIL rsp_stall_%0d: got valid=%b rd=%h/%h rq_ready=%b, required stable response, rq_ready=00",
                         c, rsp_valid, rsp_rd_s0, rsp_rd_s1, rq_ready);
            else n_pass++;
        end
        @(posedge g_clk); #1;
        rsp_ready = 1'b1;
        wait_grant(1);
        wait_rsp(lat);
        @(posedge g_clk); #1;
    endtask

    task automatic test_reset_mid();
        unit_dead = 1'b1;
        drive_req(0, 4'd2, $urandom, $urandom, $urandom, $urandom);
        wait_grant(0);
        repeat (3) @(posedge g_clk);
        #1;
        g_reset = 1'b1;
        @(negedge g_clk);
        n_checks++;
        if (uif.flush !== 1'b1) $display("FAIL midreset_flush: got u_flush=%b, required 1", uif.flush);
        else n_pass++;
        @(posedge g_clk); #1;
        g_reset   = 1'b0;
        unit_dead = 1'b0;
        sb_q.delete();
        @(negedge g_clk);
        n_checks++;
        if ({uif.valid, uif.op, uif.flush, uif.prng_update, rsp_valid, rsp_err, rq_ready} !== 16'h0)
            $display("FAIL midreset_idle: got u_valid=%b u_op=%h flush=%b prng=%b rsp_valid=%b, required all 0",
                     uif.valid, uif.op, uif.flush, uif.prng_update, rsp_valid);
        else n_pass++;
        n_checks++;
        if ({uif.rs1_s0, uif.rs1_s1, uif.rs2_s0, uif.rs2_s1} !== 128'h0)
            $display("FAIL midreset_operands: got nonzero unit operands, required 0");
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge g_clk);
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL midreset_norsp_%0d: got rsp_valid=%b, required 0", c, rsp_valid);
            else n_pass++;
        end
        @(posedge g_clk); #1;
        ready_lat = 1;
        drive_req(0, 4'd0, $urandom, $urandom, $urandom, $urandom);
        drive_req(1, 4'd3, $urandom, $urandom, $urandom, $urandom);
        @(negedge g_clk);
        n_checks++;
        if (rq_ready !== 2'b01) $display("FAIL midreset_rrptr: got rq_ready=%b, required 01", rq_ready);
        else n_pass++;
        @(posedge g_clk); #1;
        rq_valid[0] = 1'b0;
        wait_grant(1);
        for (int w = 0; w < 100 && sb_q.size() != 0; w++) @(negedge g_clk);
        @(posedge g_clk); #1;
    endtask

    initial begin
        g_reset   = 1'b1;
        rq_valid  = 2'b00;
        rq_op     = 8'h0;
        rq_rs1_s0 = 64'h0;
        rq_rs1_s1 = 64'h0;
        rq_rs2_s0 = 64'h0;
        rq_rs2_s1 = 64'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_xor();
        test_slli();
        test_back_to_back();
        test_bmask();
        test_timeout();
        test_illegal();
        test_rsp_stall();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL final_drain: got %0d outstanding, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
